// File: rtl/tx_symbol_scheduler.sv
// Transmit symbol scheduler feeding encoder_8b10b: link bytes, idle fill, periodic SKP ordered sets.
// Define TX_SCHED_EIOS_EN to compile in the EIOS / electrical-idle sequencing path.
module tx_symbol_scheduler #(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_COUNT    = 3,
    parameter int CNT_W        = 11
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] in_data_i,
    input  logic       in_k_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic       eidle_req_i,
    output logic [7:0] data_o,
    output logic       is_special_k_o,
    output logic       eidle_o,
    output logic       skp_active_o
);

    localparam logic [7:0] SYM_COM  = 8'hBC;
    localparam logic [7:0] SYM_SKP  = 8'h1C;
    localparam logic [7:0] SYM_FILL = 8'h00;
    localparam logic [CNT_W-1:0] SKP_LAST     = CNT_W'(SKP_INTERVAL - 1);
    localparam logic [2:0]       SKP_LAST_IDX = 3'(SKP_COUNT);

`ifdef TX_SCHED_EIOS_EN
    localparam logic [7:0] SYM_IDL       = 8'h7C;
    localparam logic [2:0] EIOS_LAST_IDX = 3'd3;

    typedef enum logic [1:0] {
        S_DATA  = 2'd0,
        S_SKP   = 2'd1,
        S_EIOS  = 2'd2,
        S_EIDLE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_SKP  = 2'd1
    } state_t;

    logic unused_eidle_req_s;
    assign unused_eidle_req_s = eidle_req_i;
`endif

    state_t           state_r;
    logic [CNT_W-1:0] sym_cnt_r;
    logic [2:0]       os_idx_r;
    logic [7:0]       data_r;
    logic             k_r;
    logic             eidle_r;
    logic             skp_r;

    // Ready depends on state only so the source never sees a valid-to-ready loop.
    assign in_ready_o     = (state_r == S_DATA) && !reset_i;
    assign data_o         = data_r;
    assign is_special_k_o = k_r;
    assign eidle_o        = eidle_r;
    assign skp_active_o   = skp_r;

    // Scheduler FSM: picks the symbol for the next cycle and registers it onto the outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= S_DATA;
            sym_cnt_r <= {CNT_W{1'b0}};
            os_idx_r  <= 3'd0;
            data_r    <= SYM_FILL;
            k_r       <= 1'b0;
            eidle_r   <= 1'b0;
            skp_r     <= 1'b0;
        end else begin
            case (state_r)
                S_DATA: begin
                    eidle_r <= 1'b0;
                    skp_r   <= 1'b0;
                    if (in_valid_i) begin
                        data_r <= in_data_i;
                        k_r    <= in_k_i;
                    end else begin
                        data_r <= SYM_FILL;
                        k_r    <= 1'b0;
                    end
                    // The SKP boundary wins over an electrical-idle request.
                    if (sym_cnt_r == SKP_LAST) begin
                        state_r   <= S_SKP;
                        sym_cnt_r <= {CNT_W{1'b0}};
                        os_idx_r  <= 3'd0;
                    end
`ifdef TX_SCHED_EIOS_EN
                    else if (eidle_req_i) begin
                        state_r   <= S_EIOS;
                        sym_cnt_r <= sym_cnt_r + CNT_W'(1);
                        os_idx_r  <= 3'd0;
                    end
`endif
                    else begin
                        sym_cnt_r <= sym_cnt_r + CNT_W'(1);
                    end
                end
                S_SKP: begin
                    eidle_r <= 1'b0;
                    skp_r   <= 1'b1;
                    k_r     <= 1'b1;
                    data_r  <= (os_idx_r == 3'd0) ? SYM_COM : SYM_SKP;
                    if (os_idx_r == SKP_LAST_IDX) begin
                        state_r   <= S_DATA;
                        os_idx_r  <= 3'd0;
                        sym_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        os_idx_r <= os_idx_r + 3'd1;
                    end
                end
`ifdef TX_SCHED_EIOS_EN
                S_EIOS: begin
                    eidle_r <= 1'b0;
                    skp_r   <= 1'b0;
                    k_r     <= 1'b1;
                    data_r  <= (os_idx_r == 3'd0) ? SYM_COM : SYM_IDL;
                    if (os_idx_r == EIOS_LAST_IDX) begin
                        state_r  <= S_EIDLE;
                        os_idx_r <= 3'd0;
                    end else begin
                        os_idx_r <= os_idx_r + 3'd1;
                    end
                end
                S_EIDLE: begin
                    eidle_r <= 1'b1;
                    skp_r   <= 1'b0;
                    k_r     <= 1'b0;
                    data_r  <= SYM_FILL;
                    if (!eidle_req_i) begin
                        state_r   <= S_DATA;
                        sym_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= S_EIDLE;
                    end
                end
`endif
                default: begin
                    state_r   <= S_DATA;
                    sym_cnt_r <= {CNT_W{1'b0}};
                    os_idx_r  <= 3'd0;
                    data_r    <= SYM_FILL;
                    k_r       <= 1'b0;
                    eidle_r   <= 1'b0;
                    skp_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Bench for tx_symbol_scheduler: directed scenarios plus random traffic against a queue-based symbol model.
module tb_tx_symbol_scheduler;

    localparam int INTERVAL = 8;
    localparam int COUNT    = 3;
    localparam int CW       = 4;
`ifdef TX_SCHED_EIOS_EN
    localparam bit EIOS_ON = 1'b1;
`else
    localparam bit EIOS_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_k = 1'b0;
    logic       in_valid = 1'b0;
    logic       eidle_req = 1'b0;
    logic       in_ready;
    logic [7:0] data_o;
    logic       is_special_k_o;
    logic       eidle_o;
    logic       skp_active_o;

    always #5 clk = ~clk;

    tx_symbol_scheduler #(
        .SKP_INTERVAL(INTERVAL),
        .SKP_COUNT   (COUNT),
        .CNT_W       (CW)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .in_data_i     (in_data),
        .in_k_i        (in_k),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .eidle_req_i   (eidle_req),
        .data_o        (data_o),
        .is_special_k_o(is_special_k_o),
        .eidle_o       (eidle_o),
        .skp_active_o  (skp_active_o)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       skp;
        logic       eid;
    } sym_t;

    sym_t osq[$];
    sym_t exp_out = '0;
    int   run = 0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   acc = 1'b0;
    logic [7:0] seen_d [0:63];
    logic       seen_k [0:63];
    logic       seen_e [0:63];
    logic       seen_s [0:63];
    logic       seen_r [0:63];
    logic [7:0] last_d;
    logic       last_k;
    logic       last_s;

    function automatic sym_t mk(input logic [7:0] d, input logic k, input logic s, input logic e);
        sym_t r;
        r.d = d; r.k = k; r.skp = s; r.eid = e;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock: check outputs, advance the reference model from the applied inputs, clock the DUT.
    task automatic step();
        sym_t nxt;
        logic exp_ready;
        @(negedge clk);
        last_d = data_o; last_k = is_special_k_o; last_s = skp_active_o;
        if (cyc < 64) begin
            seen_d[cyc] = data_o; seen_k[cyc] = is_special_k_o; seen_e[cyc] = eidle_o;
            seen_s[cyc] = skp_active_o; seen_r[cyc] = in_ready;
        end
        chk("data_o", 32'(data_o), 32'(exp_out.d));
        chk("is_special_k_o", 32'(is_special_k_o), 32'(exp_out.k));
        chk("skp_active_o", 32'(skp_active_o), 32'(exp_out.skp));
        chk("eidle_o", 32'(eidle_o), 32'(exp_out.eid));
        if (reset) begin
            exp_ready = 1'b0;
            nxt = '0;
            osq.delete();
            run = 0;
        end else if (osq.size() != 0) begin
            exp_ready = 1'b0;
            nxt = osq[0];
            if (!nxt.eid || !(EIOS_ON && eidle_req)) void'(osq.pop_front());
        end else begin
            exp_ready = 1'b1;
            nxt = in_valid ? mk(in_data, in_k, 1'b0, 1'b0) : '0;
            run++;
            if (run == INTERVAL) begin
                osq.push_back(mk(8'hBC, 1'b1, 1'b1, 1'b0));
                for (int i = 0; i < COUNT; i++) osq.push_back(mk(8'h1C, 1'b1, 1'b1, 1'b0));
                run = 0;
            end else if (EIOS_ON && eidle_req) begin
                osq.push_back(mk(8'hBC, 1'b1, 1'b0, 1'b0));
                for (int i = 0; i < 3; i++) osq.push_back(mk(8'h7C, 1'b1, 1'b0, 1'b0));
                osq.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1));
                run = 0;
            end
        end
        chk("in_ready_o", 32'(in_ready), 32'(exp_ready));
        acc = exp_ready && in_valid;
        @(posedge clk);
        #1;
        exp_out = nxt;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_k = 1'b0; eidle_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int   cnt;
        bit   found;
        logic [7:0] kq[$];
        logic [7:0] kexp [0:11];

        // Reset state, then idle fill with periodic SKP sets
        step();
        step();
        reset = 1'b0;
        cyc = 0;
        for (int i = 0; i < 24; i++) step();
        cnt = 0;
        for (int i = 0; i < 24; i++) if (!seen_r[i]) cnt++;
        chk("ready_low_count", 32'(cnt), 32'd8);
        chk("idle_com_pos", 32'(seen_d[9]), 32'hBC);
        chk("idle_period", 32'(seen_d[21]), 32'hBC);

        // Counting data stream across a SKP boundary
        do_reset();
        in_valid = 1'b1; in_data = 8'h00; in_k = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (acc) in_data = in_data + 8'd1;
        end
        for (int i = 1; i <= 8; i++) chk("stream_byte", 32'(seen_d[i]), 32'(i - 1));
        chk("stream_com", 32'(seen_d[9]), 32'hBC);
        chk("stream_resume", 32'(seen_d[13]), 32'h08);

        // K passthrough
        in_data = 8'hFB; in_k = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_k = 1'b0;
        step();
        chk("k_pass_data", 32'(last_d), 32'hFB);
        chk("k_pass_flag", 32'(last_k), 32'd1);

        // Electrical idle request mid-data
        do_reset();
        for (int i = 0; i < 3; i++) step();
        eidle_req = 1'b1;
        for (int i = 0; i < 10; i++) step();
        eidle_req = 1'b0;
        for (int i = 0; i < 12; i++) step();
        cnt = 0;
        for (int i = 0; i < 25; i++) if (seen_e[i]) cnt++;
        chk("eidle_cycles", 32'(cnt), EIOS_ON ? 32'd6 : 32'd0);
        chk("eios_com", 32'(seen_d[5]), EIOS_ON ? 32'hBC : 32'h00);
        chk("post_eidle_skp", 32'(EIOS_ON ? seen_d[23] : seen_d[21]), 32'hBC);

        // SKP boundary coincides with the idle request
        do_reset();
        for (int i = 0; i < 7; i++) step();
        eidle_req = 1'b1;
        for (int i = 0; i < 8; i++) step();
        eidle_req = 1'b0;
        for (int i = 0; i < 16; i++) step();
        for (int i = 0; i < 31; i++) if (seen_k[i]) kq.push_back(seen_d[i]);
        for (int i = 0; i < 12; i++) kexp[i] = (i % 4 == 0) ? 8'hBC : 8'h1C;
        if (EIOS_ON) for (int i = 5; i < 8; i++) kexp[i] = 8'h7C;
        chk("coincide_kcount", 32'(kq.size()), EIOS_ON ? 32'd12 : 32'd8);
        for (int i = 0; i < kq.size() && i < 12; i++) chk("coincide_order", 32'(kq[i]), 32'(kexp[i]));

        // Reset during a SKP ordered set
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (last_d == 8'h1C && last_k) found = 1'b1;
        end
        chk("find_skp", 32'(found), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc = 0;
        step();
        chk("midskp_rst_data", 32'(last_d), 32'h00);
        chk("midskp_rst_k", 32'(last_k), 32'd0);
        chk("midskp_rst_skp", 32'(last_s), 32'd0);
        for (int i = 0; i < 9; i++) step();
        cnt = 0;
        for (int i = 1; i <= 8; i++) if (seen_s[i]) cnt++;
        chk("midskp_data_run", 32'(cnt), 32'd0);
        chk("midskp_next_com", 32'(seen_d[9]), 32'hBC);

        // Random traffic with idle requests and occasional resets
        for (int n = 0; n < 1500; n++) begin
            if ((in_valid && acc) || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
                in_k     = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 59) == 0) eidle_req = ~eidle_req;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_symbol_scheduler.md
# tx_symbol_scheduler

Transmit-side symbol scheduler that sits directly in front of `encoder_8b10b` and produces exactly one byte plus K-flag per clock for it to encode. It accepts link-layer bytes over a valid/ready handshake and fills idle cycles with D0.0. It inserts SKP ordered sets (COM + SKP_COUNT × SKP) every SKP_INTERVAL symbols. Optionally, it sequences an Electrical Idle Ordered Set followed by electrical idle.

## Interface
- `SKP_INTERVAL`, 1180, number of S_DATA symbols between SKP ordered sets; must be ≥2.
- `SKP_COUNT`, 3, number of SKP symbols following COM in each SKP ordered set; range 1–5.
- `CNT_W`, 11, width of the symbol counter; must satisfy 2^CNT_W > SKP_INTERVAL.
- `clk_i`  in  1  symbol clock, same clock as `encoder_8b10b`.
- `reset_i`  in  1  reset, synchronous, active-high.
- `in_data_i`  in  8  link-layer byte.
- `in_k_i`  in  1  link-layer byte is a control (K) symbol.
- `in_valid_i`  in  1  byte valid.
- `in_ready_o`  out  1  scheduler accepts the byte this cycle.
- `eidle_req_i`  in  1  request to enter electrical idle; level-sensitive.
- `data_o`  out  8  byte to `encoder_8b10b.data_i`.
- `is_special_k_o`  out  1  to `encoder_8b10b.is_special_k_i`.
- `eidle_o`  out  1  transmitter is in electrical idle.
- `skp_active_o`  out  1  current `data_o` belongs to a SKP ordered set.

## Operation
- Symbol constants:
  - COM = 0xBC, K=1.
  - SKP = 0x1C, K=1.
  - IDL = 0x7C, K=1.
  - Idle fill = 0x00, K=0.
- FSM states: S_DATA, S_SKP, S_EIOS, S_EIDLE. Reset state is S_DATA.
- `in_ready_o` = (state == S_DATA) && !reset_i. It is combinational from state only and never depends on `in_valid_i`.
- **S_DATA:**
  - Transfer occurs when valid && ready. The next symbol is {`in_data_i`, `in_k_i`}.
  - Otherwise the next symbol is idle fill.
  - `sym_cnt` increments on every S_DATA cycle.
- **SKP scheduling:**
  - On the S_DATA cycle where `sym_cnt == SKP_INTERVAL-1`, that cycle's symbol is issued normally.
  - The FSM then moves to S_SKP.
- **S_SKP:**
  - Issues COM, then SKP_COUNT × SKP, using sub-counter `os_idx`.
  - After the last SKP, the FSM returns to S_DATA with `sym_cnt = 0`.
- **EIOS entry:**
  - In S_DATA, `eidle_req_i` = 1 moves the FSM to S_EIOS after the current symbol.
  - Exception: on the SKP boundary cycle, SKP takes priority. `eidle_req_i` is re-evaluated on the first S_DATA cycle after the SKP ordered set.
- **S_EIOS:** issues COM, IDL, IDL, IDL, then moves to S_EIDLE.
- **S_EIDLE:**
  - Symbol is idle fill and `eidle_o` = 1.
  - The FSM holds while `eidle_req_i` = 1.
  - On deassertion, it returns to S_DATA with `sym_cnt = 0`.
- Deasserting `eidle_req_i` during S_EIOS does not abort the set. S_EIDLE is still entered for at least one cycle.
- `sym_cnt` is frozen in S_SKP, S_EIOS and S_EIDLE.
- Arithmetic: `sym_cnt` is compared for equality only. No wrap occurs, because it is cleared at SKP_INTERVAL-1.

## Timing
- `data_o`, `is_special_k_o`, `eidle_o` and `skp_active_o` are registered.
- A symbol chosen in cycle t appears on the outputs in cycle t+1. Byte accept-to-output latency is 1 clock.
- Reset values: `data_o` = 0x00, `is_special_k_o` = 0, `eidle_o` = 0, `skp_active_o` = 0, `sym_cnt` = 0, `os_idx` = 0.
- `in_ready_o` is 0 while `reset_i` is high, and 1 in the first cycle after it falls.
- Reset asserted mid-ordered-set aborts it. All registers take their reset values at that edge, and the remaining ordered-set symbols are not issued.
- With default parameters, the SKP period is SKP_INTERVAL + 1 + SKP_COUNT = 1184 cycles. While `eidle_req_i` stays low, the S_DATA cycles between SKP ordered sets number exactly SKP_INTERVAL.
- `in_ready_o` is low for exactly 1 + SKP_COUNT cycles per SKP ordered set.
- A non-accepted `in_valid_i` byte must be held stable by the source. It is accepted on the first ready cycle.

## Configuration
- Macro: `TX_SCHED_EIOS_EN`.
- **Defined:** the EIOS/electrical-idle path (S_EIOS and S_EIDLE) is compiled in, exactly as described above.
- **Not defined:**
  - S_EIOS and S_EIDLE are not compiled in.
  - `eidle_req_i` is ignored.
  - `eidle_o` is tied to 0.
  - The port list is unchanged.

## Test plan
- **Reset release, idle fill:** SKP_INTERVAL=8, SKP_COUNT=3, `in_valid_i`=0, release reset.
  - Required: 8 cycles of 0x00/K=0, then BC/K, 1C/K, 1C/K, 1C/K, repeating with period 12.
  - `in_ready_o` must be low exactly during the 4 ordered-set symbols.
- **Data stream:** hold `in_valid_i`=1 with a counting byte 0x00, 0x01, … incremented only on accept.
  - Required: `data_o` = 0x00 through 0x07 in consecutive cycles, then the SKP set, then 0x08 onward.
  - No byte lost or duplicated.
- **K passthrough:** send 0xFB with `in_k_i`=1. Required: the next cycle shows `data_o`=0xFB, `is_special_k_o`=1.
- **EIOS with macro defined:** pulse `eidle_req_i` high for 10 cycles mid-data.
  - Required: BC/K, 7C/K, 7C/K, 7C/K, then `eidle_o`=1 until 1 cycle after deassert.
  - Then S_DATA resumes with `sym_cnt`=0.
- **Simultaneous SKP boundary and EIOS request:** required order is the SKP set first, then the EIOS set. Repeat without the macro: `eidle_o` stays 0 and no EIOS appears.
- **Reset mid-SKP:** assert `reset_i` on the second SKP symbol.
  - Required: the next cycle shows outputs at reset values.
  - After reset release, a full SKP_INTERVAL of data precedes the next COM.
